// File: rtl/alu_pipe_fu.sv
// Pipelined RV32I/RV64I register-register ALU carrying a ROB tag, with valid/ready backpressure,
// bubble collapsing and synchronous flush. Define ALU_FU_PERF_EN to add perf_ops/perf_stall counters.
module alu_pipe_fu #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef ALU_FU_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic [STAGES-1:0] v_q, v_d, adv, load;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [STAGES-1:0] ill_q;
  logic [XLEN-1:0]   alu_res;
  logic              alu_ill;
  logic [SH_W-1:0]   shamt;
  logic              accept;

  assign shamt = in_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_op)
      4'b0000: alu_res = in_a + in_b;
      4'b1000: alu_res = in_a + ~in_b + ONE;
      4'b0001: alu_res = in_a << shamt;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      4'b0100: alu_res = in_a ^ in_b;
      4'b0101: alu_res = in_a >> shamt;
      4'b1101: alu_res = $unsigned($signed(in_a) >>> shamt);
      4'b0110: alu_res = in_a | in_b;
      4'b0111: alu_res = in_a & in_b;
      default: alu_ill = 1'b1;
    endcase
  end

  // A stage may load if it is empty or its occupant moves on; an empty stage anywhere
  // downstream lets everything behind it advance, which collapses bubbles.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready;
    for (int i = STAGES - 2; i >= 0; i--) adv[i] = !v_q[i+1] || adv[i+1];
    load     = ~v_q | adv;
    in_ready = load[0] && !flush;
    accept   = in_valid && in_ready;
    v_d = v_q;
    if (load[0]) v_d[0] = accept;
    for (int i = 1; i < STAGES; i++) if (load[i]) v_d[i] = v_q[i-1];
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      ill_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      if (accept) begin
        res_q[0] <= alu_res;
        tag_q[0] <= in_tag;
        ill_q[0] <= alu_ill;
      end
      // Payload only moves with a valid op so empty stages keep their last contents.
      for (int i = 1; i < STAGES; i++) begin
        if (load[i] && v_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          tag_q[i] <= tag_q[i-1];
          ill_q[i] <= ill_q[i-1];
        end
      end
    end
  end

  assign out_valid   = v_q[STAGES-1];
  assign out_result  = res_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];

`ifdef ALU_FU_PERF_EN
  logic [31:0] ops_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && out_ready && !flush) ops_q <= ops_q + 32'd1;
      if (in_valid && !in_ready && !flush)  stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_pipe_fu.sv
// Randomized bench for alu_pipe_fu: a queue-of-ops reference model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_alu_pipe_fu;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 6;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef ALU_FU_PERF_EN
  logic [31:0] perf_ops, perf_stall;
  logic [31:0] m_ops = 0, m_stall = 0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe_fu #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
`ifdef ALU_FU_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             ill;
    int               pos;
  } ent_t;

  ent_t q[$];

  // Returns {illegal, result}.
  function automatic logic [XLEN:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] ones;
    logic [XLEN-1:0] r;
    int sh;
    ones = '1;
    sh = int'(b % XLEN);
    r = '0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << sh;
      4'b0010: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: r = (a < b) ? 1 : 0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b1101: r = (a >> sh) | (a[XLEN-1] ? ~(ones >> sh) : '0);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare outputs with the model,
  // then move the model across the coming rising edge.
  task automatic step(input bit iv, input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      input bit ordy, input bit fl, output bit acc);
    ent_t tmp[$];
    ent_t e;
    bit exp_v, free0;
    logic [XLEN:0] r;
    @(negedge clk);
    in_valid = iv; in_op = op; in_a = a; in_b = b; in_tag = tag;
    out_ready = ordy; flush = fl;
    #1;
    tmp = q;
    exp_v = (q.size() > 0) && (q[0].pos == STAGES - 1);
    if (exp_v && ordy) void'(tmp.pop_front());
    for (int i = 0; i < tmp.size(); i++) begin
      int lim;
      lim = (i == 0) ? STAGES - 1 : tmp[i-1].pos - 1;
      if (tmp[i].pos < lim) tmp[i].pos = tmp[i].pos + 1;
    end
    free0 = (tmp.size() == 0) || (tmp[tmp.size()-1].pos > 0);
    chk("in_ready", in_ready, free0 && !fl);
    chk("out_valid", out_valid, exp_v);
    if (exp_v) begin
      chk("out_result", out_result, q[0].res);
      chk("out_tag", out_tag, q[0].tag);
      chk("out_illegal", out_illegal, q[0].ill);
    end
`ifdef ALU_FU_PERF_EN
    chk("perf_ops", perf_ops, m_ops);
    chk("perf_stall", perf_stall, m_stall);
    if (exp_v && ordy && !fl) m_ops = m_ops + 1;
    if (iv && !(free0 && !fl) && !fl) m_stall = m_stall + 1;
`endif
    acc = iv && free0 && !fl;
    if (fl) q.delete();
    else begin
      q = tmp;
      if (acc) begin
        r = ref_alu(op, a, b);
        e.res = r[XLEN-1:0]; e.tag = tag; e.ill = r[XLEN]; e.pos = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 4'h0, '0, '0, '0, ordy, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < STAGES + 2; i++) idle(1'b1);
  endtask

  initial begin
    bit acc;
    int sent;
    logic [XLEN-1:0] specials [6];
    specials[0] = 32'h0; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h80000000;
    specials[3] = 32'h7FFFFFFF; specials[4] = 32'h1; specials[5] = 32'h21;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b1;

    // Model pins
    chk("pin_add", ref_alu(4'b0000, 32'h7FFFFFFF, 32'h1), {1'b0, 32'h80000000});
    chk("pin_sub", ref_alu(4'b1000, 32'h0, 32'h1), {1'b0, 32'hFFFFFFFF});
    chk("pin_sra", ref_alu(4'b1101, 32'h80000000, 32'h21), {1'b0, 32'hC0000000});
    chk("pin_srl", ref_alu(4'b0101, 32'h80000000, 32'h21), {1'b0, 32'h40000000});
    chk("pin_slt", ref_alu(4'b0010, 32'hFFFFFFFF, 32'h1), {1'b0, 32'h1});
    chk("pin_sltu", ref_alu(4'b0011, 32'hFFFFFFFF, 32'h1), {1'b0, 32'h0});
    chk("pin_ill", ref_alu(4'b1111, 32'h5, 32'h6), {1'b1, 32'h0});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef ALU_FU_PERF_EN
    chk("rst_perf_ops", perf_ops, 0);
`endif

    // ADD / SUB latency
    step(1'b1, 4'b0000, 32'h7FFFFFFF, 32'h1, 6'd3, 1'b1, 1'b0, acc);
    step(1'b1, 4'b1000, 32'h0, 32'h1, 6'd4, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("add_result", out_result, 32'h80000000);
    chk("add_tag", out_tag, 6'd3);
    idle(1'b1);
    chk("sub_result", out_result, 32'hFFFFFFFF);
    chk("sub_tag", out_tag, 6'd4);

    // Shifts and compares, back to back
    step(1'b1, 4'b1101, 32'h80000000, 32'h21, 6'd5, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0101, 32'h80000000, 32'h21, 6'd6, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0010, 32'hFFFFFFFF, 32'h1, 6'd7, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0011, 32'hFFFFFFFF, 32'h1, 6'd8, 1'b1, 1'b0, acc);
    step(1'b1, 4'b1111, 32'h12345678, 32'h9, 6'd9, 1'b1, 1'b0, acc);
    drain();
    step(1'b1, 4'b1111, 32'h12345678, 32'h9, 6'd9, 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_result", out_result, 0);
    chk("ill_tag", out_tag, 6'd9);
    drain();

    // Backpressure: 6 ops streamed while out_ready is held low for 4 cycles
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      step(sent < 6, 4'b0000, 32'(sent), 32'd100, 6'(10 + sent), c >= 4, 1'b0, acc);
      if (c == 2) chk("bp_in_ready_low", in_ready, 0);
      if (acc) sent++;
    end
    chk("bp_all_sent", sent, 6);
    chk("bp_drained", q.size(), 0);

    // Bubble collapse
    step(1'b1, 4'b0110, 32'hF0, 32'h0F, 6'd20, 1'b1, 1'b0, acc);
    idle(1'b0);
    step(1'b1, 4'b0111, 32'hFF, 32'h0F, 6'd21, 1'b0, 1'b0, acc);
    chk("bub_accept", acc, 1);
    idle(1'b0);
    chk("bub_full", in_ready, 0);
    chk("bub_head_tag", out_tag, 6'd20);
    drain();

    // Flush with an op offered in the flush cycle
    step(1'b1, 4'b0000, 32'd1, 32'd2, 6'd30, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0000, 32'd3, 32'd4, 6'd31, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0000, 32'd5, 32'd6, 6'd32, 1'b1, 1'b0, acc);
    step(1'b1, 4'b0000, 32'd7, 32'd8, 6'd33, 1'b1, 1'b1, acc);
    chk("fl_in_ready", in_ready, 0);
    idle(1'b1);
    chk("fl_no_out1", out_valid, 0);
    idle(1'b1);
    chk("fl_no_out2", out_valid, 0);
    step(1'b1, 4'b0000, 32'd5, 32'd6, 6'd34, 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    chk("fl_next_valid", out_valid, 1);
    chk("fl_next_result", out_result, 32'd11);
    chk("fl_next_tag", out_tag, 6'd34);
    drain();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [XLEN-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      step($urandom_range(0, 9) < 7, 4'($urandom), a, b, 6'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
    end
    drain();

    // Asynchronous reset between edges with ops in flight
    step(1'b1, 4'b0000, 32'd1, 32'd1, 6'd40, 1'b0, 1'b0, acc);
    step(1'b1, 4'b0000, 32'd2, 32'd2, 6'd41, 1'b0, 1'b0, acc);
    idle(1'b0);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
`ifdef ALU_FU_PERF_EN
    chk("mid_rst_perf_ops", perf_ops, 0);
    m_ops = 0;
    m_stall = 0;
`endif
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'b0100, 32'hA5, 32'h5A, 6'd42, 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_result", out_result, 32'hFF);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_pipe_fu.md
# alu_pipe_fu

Parametrised, pipelined integer ALU functional unit for the out-of-order engine. It accepts one RV32I/RV64I register-register ALU operation per cycle from the issue stage over a valid/ready handshake and carries a ROB tag alongside the data. It returns the result after a configurable number of pipeline stages, with per-stage backpressure, bubble collapsing and a synchronous flush for branch-mispredict recovery.

## Interface
- XLEN, 32, operand/result width; power of two, 8..64
- STAGES, 2, pipeline depth in registers, 1..4
- TAG_W, 6, ROB tag width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight ops
- in_valid  input  1  issue offers an op
- in_ready  output  1  FU accepts op this cycle
- in_op  input  4  {funct7[5], funct3} operation code
- in_a, in_b  input  XLEN  source operands
- in_tag  input  TAG_W  ROB tag
- out_valid  output  1  result available
- out_ready  input  1  writeback/CDB accepts result
- out_result  output  XLEN  result
- out_tag  output  TAG_W  tag of out_result
- out_illegal  output  1  op code was unsupported
- perf_ops, perf_stall  output  32 each  only with ALU_FU_PERF_EN (see Configuration)

## Operation
- Op codes: 0000 ADD, 1000 SUB (a + ~b + 1), 0001 SLL, 0010 SLT (signed), 0011 SLTU (unsigned), 0100 XOR, 0101 SRL, 1101 SRA (arithmetic, sign-filled), 0110 OR, 0111 AND.
- All other codes: result 0, out_illegal=1, tag still delivered.
- Shift amount = in_b[$clog2(XLEN)-1:0]; upper bits of in_b ignored.
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- SLT/SLTU produce 1 or 0 zero-extended to XLEN.
- Result computed combinationally on stage-0 input, then registered into stage 0 with tag and illegal bit. Stages 1..STAGES-1 only transport.
- Stage i holds v[i] plus payload. adv[STAGES-1] = out_ready. adv[i] = !v[i+1] || adv[i+1]. Stage i loads when !v[i] || adv[i].
- in_ready = (!v[0] || adv[0]) && !flush. A transfer occurs when in_valid && in_ready.
- Outputs are driven directly from stage STAGES-1; out_valid = v[STAGES-1].
- Payload registers of an empty stage hold their last value. Only v[] matters.
- flush: at the next edge all v[] clear. The input offered in the flush cycle is not accepted. out_valid may be high in the flush cycle, and the consumer must ignore it.

## Timing
- Reset (async): all v[]=0, payloads=0; out_valid=0, out_result=0, out_tag=0, out_illegal=0, perf counters=0. in_ready=1 in the first cycle after rst deasserts (flush low).
- Latency: op accepted at edge N appears with out_valid=1 after edge N+STAGES-1. For example, STAGES=1 gives a result in the cycle after acceptance.
- Throughput: 1 op/cycle while out_ready=1.
- Stall: out_ready=0 with a full pipe gives in_ready=0 combinationally in the same cycle. An empty stage lets upstream ops advance, collapsing bubbles.
- out_* payload stays stable while out_valid && !out_ready.
- Reset asserted mid-stream drops all in-flight ops immediately. No partial output.
- flush and out_ready both high in the same cycle: the flush wins, and the head op is counted neither as delivered nor retired.

## Configuration
- ALU_FU_PERF_EN defined: perf_ops and perf_stall ports exist.
  - perf_ops increments on every out_valid && out_ready && !flush.
  - perf_stall increments on every cycle with in_valid && !in_ready && !flush.
  - Both counters wrap at 2^32 and are cleared only by rst.
- ALU_FU_PERF_EN undefined: the ports and counters are absent. Remaining behaviour is identical.

## Test plan
- XLEN=32, STAGES=2, out_ready=1: ADD 0x7FFFFFFF+1 tag 3 -> 0x80000000 tag 3 two cycles later. SUB 0−1 -> 0xFFFFFFFF.
- Shifts and compares: SRA 0x80000000 by b=0x21 -> 0xC0000000 (shamt 1). SRL same -> 0x40000000. SLT 0xFFFFFFFF<1 -> 1. SLTU -> 0.
- Backpressure: stream 6 ops back-to-back and hold out_ready=0 for 4 cycles -> in_ready falls once 2 ops are buffered. Release -> all 6 results emerge in order, tags unchanged, none duplicated.
- Bubble collapse: STAGES=3, one op, then idle, then an op while out_ready=0 -> both ops are resident in adjacent stages. in_ready stays 1 until all 3 stages are full.
- Flush: 3 ops in flight, assert flush for 1 cycle with in_valid=1 -> no out_valid in the following cycles. The offered op is not accepted. Next op has normal latency.
- Illegal op 1111 and async rst mid-stream:
  - 1111 -> result 0, out_illegal=1.
  - rst pulse between edges -> out_valid=0 immediately, and perf_ops=0 when ALU_FU_PERF_EN is defined.
